// File: rtl/apb_master_if.sv
// Command, response and APB signal bundle for the APB initiator.
// The master modport is the initiator's view; the slave modport is the requester/bus side.
interface apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: single-beat commands become SETUP/ACCESS transfers,
// answered by a one-cycle response strobe with read data or timeout error.
module apb_master #(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic I_APBM_PCLK,
  input  logic I_APBM_PRESET,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    TIMEOUT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [31:0]            paddr_q, paddr_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic                   pwrite_q, pwrite_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = {bus.cmd_addr[31:2], 2'b00};
          pwdata_d = bus.cmd_wdata;
          pwrite_d = bus.cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 32'h0 : bus.prdata;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_APBM_PCLK) begin
    if (I_APBM_PRESET) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Handshake outputs decode straight from the registered state.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.psel      = (state_q != IDLE);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.busy      = (state_q != IDLE);
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small register slave that
// raises PREADY one cycle into ACCESS, or never when stalled.
module tb_apb_master;

  logic clk;
  logic rst;
  logic stall;
  logic [31:0] mem [16];

  apb_master_if bus ();

  apb_master #(.TIMEOUT(16), .TIMEOUT_W(8)) dut (
    .I_APBM_PCLK   (clk),
    .I_APBM_PRESET (rst),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: registered ready, word-indexed storage, 0x10 has a live low half.
  always @(posedge clk) begin
    if (rst) bus.pready <= 1'b0;
    else bus.pready <= bus.psel && bus.penable && !bus.pready && !stall;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[5:2]] <= bus.pwdata;
  end

  always_comb begin
    bus.prdata = mem[bus.paddr[5:2]];
    if (bus.paddr == 32'h10)
      bus.prdata = {mem[4][31:16], 16'h1234};
  end

  int checks;
  int errs;
  logic [31:0] rd;
  logic        er;
  logic        ok;
  int acc_cnt, n_acc, n_rsp, last_rise, bad_gap, coinc_bad, rsp_seen;
  logic prev_psel, pend, got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r,
                        output logic e, output logic done);
    done = 1'b0;
    r = '0;
    e = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.rsp_valid) begin
        r = bus.rsp_rdata;
        e = bus.rsp_err;
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    errs = 0;
    stall = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_psel", {31'b0, bus.psel}, 32'h0);
    chk("rst_penable", {31'b0, bus.penable}, 32'h0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);

    do_cmd(1'b1, 32'h0, 32'hDEADBEEF, rd, er, ok);
    chk("wr0_done", {31'b0, ok}, 32'h1);
    chk("wr0_err", {31'b0, er}, 32'h0);
    chk("wr0_rdata", rd, 32'h0);
    chk("wr0_mem", mem[0], 32'hDEADBEEF);
    do_cmd(1'b0, 32'h0, 32'h0, rd, er, ok);
    chk("rd0_rdata", rd, 32'hDEADBEEF);
    chk("rd0_err", {31'b0, er}, 32'h0);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h23;
    bus.cmd_wdata = 32'h00C0FFEE;
    tick();
    bus.cmd_valid = 1'b0;
    chk("al_setup_psel", {31'b0, bus.psel}, 32'h1);
    chk("al_setup_pen", {31'b0, bus.penable}, 32'h0);
    chk("al_setup_rdy", {31'b0, bus.cmd_ready}, 32'h0);
    chk("al_setup_paddr", bus.paddr, 32'h20);
    tick();
    chk("al_acc1_pen", {31'b0, bus.penable}, 32'h1);
    chk("al_acc1_paddr", bus.paddr, 32'h20);
    tick();
    chk("al_acc2_paddr", bus.paddr, 32'h20);
    chk("al_acc2_pwdata", bus.pwdata, 32'h00C0FFEE);
    tick();
    chk("al_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
    chk("al_rsp_psel", {31'b0, bus.psel}, 32'h0);
    tick();
    chk("al_rsp_pulse", {31'b0, bus.rsp_valid}, 32'h0);
    chk("al_mem", mem[8], 32'h00C0FFEE);

    do_cmd(1'b1, 32'h10, 32'hAAAA0000, rd, er, ok);
    do_cmd(1'b0, 32'h10, 32'h0, rd, er, ok);
    chk("rd10_rdata", rd, 32'hAAAA1234);

    stall = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    tick();
    bus.cmd_valid = 1'b0;
    acc_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.penable) acc_cnt++;
    end
    chk("to_seen", {31'b0, got}, 32'h1);
    chk("to_access_cycles", acc_cnt, 32'd16);
    chk("to_err", {31'b0, bus.rsp_err}, 32'h1);
    chk("to_rdata", bus.rsp_rdata, 32'h0);
    chk("to_psel", {31'b0, bus.psel}, 32'h0);
    stall = 1'b0;

    n_acc = 0;
    n_rsp = 0;
    last_rise = -1;
    bad_gap = 0;
    coinc_bad = 0;
    prev_psel = bus.psel;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h4;
    bus.cmd_wdata = 32'h11111111;
    for (int cyc = 0; cyc < 40; cyc++) begin
      pend = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (pend) begin
        n_acc++;
        if (n_acc < 3) begin
          bus.cmd_addr  = 32'(4 * (n_acc + 1));
          bus.cmd_wdata = 32'h11111111 * 32'(n_acc + 1);
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        if (bus.cmd_valid && !bus.cmd_ready) coinc_bad++;
      end
      if (bus.psel && !prev_psel) begin
        if (last_rise >= 0 && cyc - last_rise != 4) bad_gap++;
        last_rise = cyc;
      end
      prev_psel = bus.psel;
      if (n_rsp == 3) break;
    end
    chk("b2b_accepts", n_acc, 32'd3);
    chk("b2b_responses", n_rsp, 32'd3);
    chk("b2b_gap", bad_gap, 32'd0);
    chk("b2b_coincide", coinc_bad, 32'd0);
    chk("b2b_mem1", mem[1], 32'h11111111);
    chk("b2b_mem2", mem[2], 32'h22222222);
    chk("b2b_mem3", mem[3], 32'h33333333);

    stall = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h30;
    bus.cmd_wdata = 32'h5A5A5A5A;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("rs_in_access", {31'b0, bus.penable}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rs_psel", {31'b0, bus.psel}, 32'h0);
    chk("rs_penable", {31'b0, bus.penable}, 32'h0);
    chk("rs_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    rst = 1'b0;
    stall = 1'b0;
    tick();
    chk("rs_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
    rsp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid) rsp_seen++;
    end
    chk("rs_no_rsp", rsp_seen, 32'd0);
    chk("rs_no_write", mem[12], 32'h0);
    do_cmd(1'b0, 32'h0, 32'h0, rd, er, ok);
    chk("rs_after_rd", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
